// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the memory request arbiter: source IDs, default
// outstanding depth, grant FSM states and the downstream request payload.
package mem_req_arbiter_pkg;

    localparam int unsigned DEF_OUTST_DEPTH = 4;
    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned STRB_W          = 4;
    localparam int unsigned SIZE_W          = 3;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic              cache;
        logic              wr;
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [SIZE_W-1:0] size;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Instruction fetches are always full-word reads
    localparam logic [SIZE_W-1:0] INST_SIZE = SIZE_W'(2);

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of source IDs for requests accepted downstream but still
// waiting for their data. DEPTH must be a power of two so pointers wrap freely.
module arb_id_fifo
    import mem_req_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_OUTST_DEPTH
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_push,
    input  src_e i_push_id,
    input  logic i_pop,
    output src_e o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    src_e             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !w_empty;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
        end
    end

    // Storage needs no reset: entries are only read while valid
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_push_id;
    end

    assign o_head  = r_mem[r_rptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/mem_req_arbiter.sv
// Two-master (inst/data) to one-slave SRAM-like request arbiter with in-order
// data return routing. Define MEM_ARB_RR_EN for round-robin IDLE arbitration.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int unsigned OUTST_DEPTH = DEF_OUTST_DEPTH
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_req,
    input  logic        i_cache,
    input  logic [31:0] i_addr,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_cache,
    input  logic        d_wr,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_addr,
    input  logic [2:0]  d_size,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_cache,
    output logic        m_wr,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [2:0]  m_size,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    output logic        err_unexp
);

    arb_state_e r_state;
    src_e       r_hold_src;
    mem_req_t   r_hold_req;
    logic       r_err_unexp;

    src_e       w_pick;
    src_e       w_grant_src;
    src_e       w_head;
    mem_req_t   w_inst_req;
    mem_req_t   w_data_req;
    mem_req_t   w_payload;
    logic       w_full;
    logic       w_empty;
    logic       w_any_req;
    logic       w_m_req;
    logic       w_accept;
    logic       w_pop;

    always_comb begin
        w_inst_req       = '0;
        w_inst_req.cache = i_cache;
        w_inst_req.addr  = i_addr;
        w_inst_req.size  = INST_SIZE;
    end

    assign w_data_req = '{cache: d_cache, wr: d_wr, wstrb: d_wstrb,
                          addr: d_addr, size: d_size, wdata: d_wdata};

`ifdef MEM_ARB_RR_EN
    src_e r_last_src;

    // On contention, favour whichever source did not win the last acceptance
    always_comb begin
        w_pick = d_req ? SRC_DATA : SRC_INST;
        if (i_req && d_req) w_pick = (r_last_src == SRC_INST) ? SRC_DATA : SRC_INST;
    end

    always_ff @(posedge clk) begin
        if (!resetn)       r_last_src <= SRC_INST;
        else if (w_accept) r_last_src <= w_grant_src;
    end
`else
    assign w_pick = d_req ? SRC_DATA : SRC_INST;
`endif

    // A stalled request keeps its source and a frozen copy of its payload
    assign w_grant_src = (r_state == ST_HOLD) ? r_hold_src : w_pick;
    assign w_payload   = (r_state == ST_HOLD) ? r_hold_req :
                         ((w_grant_src == SRC_DATA) ? w_data_req : w_inst_req);

    assign w_any_req = (r_state == ST_HOLD) || i_req || d_req;
    assign w_m_req   = resetn && !w_full && w_any_req;
    assign w_accept  = w_m_req && m_addr_ok;
    assign w_pop     = resetn && m_data_ok && !w_empty;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_hold_src <= SRC_INST;
            r_hold_req <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_m_req && !m_addr_ok) begin
                        r_state    <= ST_HOLD;
                        r_hold_src <= w_grant_src;
                        r_hold_req <= w_payload;
                    end
                end
                ST_HOLD: begin
                    if (w_accept) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Data return with nothing outstanding is a protocol error; sticky until reset
    always_ff @(posedge clk) begin
        if (!resetn)                    r_err_unexp <= 1'b0;
        else if (m_data_ok && w_empty)  r_err_unexp <= 1'b1;
    end

    arb_id_fifo #(
        .DEPTH (OUTST_DEPTH)
    ) u_id_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .i_push    (w_accept),
        .i_push_id (w_grant_src),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign m_req     = w_m_req;
    assign m_cache   = w_payload.cache;
    assign m_wr      = w_payload.wr;
    assign m_wstrb   = w_payload.wstrb;
    assign m_addr    = w_payload.addr;
    assign m_size    = w_payload.size;
    assign m_wdata   = w_payload.wdata;

    assign i_addr_ok = w_accept && (w_grant_src == SRC_INST);
    assign d_addr_ok = w_accept && (w_grant_src == SRC_DATA);
    assign i_data_ok = w_pop && (w_head == SRC_INST);
    assign d_data_ok = w_pop && (w_head == SRC_DATA);
    assign i_rdata   = i_data_ok ? m_rdata : '0;
    assign d_rdata   = d_data_ok ? m_rdata : '0;
    assign err_unexp = r_err_unexp;

endmodule
